// File: rtl/firefly_flash_gen.sv
// Firefly flash pulse train: fixed period, four-entry width pattern.
// Define FLASH_LOOP_EN for free-running flashes gated by sta.
module firefly_flash_gen #(
   parameter int TICKS_PER_US = 50,
   parameter int PERIOD_US    = 1000,
   parameter int NUM_FLASH    = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sta,
   input  logic       wr_en,
   input  logic [1:0] wr_idx,
   input  logic [9:0] wr_us,
   output logic       f0,
   output logic       busy,
   output logic       done
);

   localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
   localparam int UW = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
   localparam int CW = (UW > 10) ? UW : 10;
   localparam logic [PW-1:0] PS_MAX = PW'(TICKS_PER_US - 1);
   localparam logic [UW-1:0] US_MAX = UW'(PERIOD_US - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ps_q, ps_d;
   logic [UW-1:0]   us_q, us_d;
   logic [1:0]      idx_q, idx_d, idx_n;
   logic [9:0]      width_q, width_d;
   logic [9:0]      pat_q [4];
   logic [9:0]      pat_wt [4];
   logic            f0_d, busy_d, done_d;
   logic            period_end;

`ifndef FLASH_LOOP_EN
   localparam int FW = $clog2(NUM_FLASH + 1);
   localparam logic [FW-1:0] CNT_LAST = FW'(NUM_FLASH - 1);
   logic [FW-1:0]   cnt_q, cnt_d;
`endif

   // A write on the latch edge must be seen by the period being latched
   always_comb begin
      for (int i = 0; i < 4; i++)
         pat_wt[i] = (wr_en && wr_idx == 2'(i)) ? wr_us : pat_q[i];
   end

   assign idx_n      = idx_q + 2'd1;
   assign period_end = (ps_q == PS_MAX) && (us_q == US_MAX);

   always_comb begin
      state_d = state_q;
      ps_d    = ps_q;
      us_d    = us_q;
      idx_d   = idx_q;
      width_d = width_q;
`ifndef FLASH_LOOP_EN
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (sta) begin
               state_d = RUN;
               ps_d    = '0;
               us_d    = '0;
               idx_d   = '0;
               width_d = pat_wt[0];
`ifndef FLASH_LOOP_EN
               cnt_d   = '0;
`endif
            end
         end
         RUN: begin
            ps_d = ps_q + PW'(1);
            if (ps_q == PS_MAX) begin
               ps_d = '0;
               us_d = us_q + UW'(1);
            end
            if (period_end) begin
               us_d    = '0;
               idx_d   = idx_n;
               width_d = pat_wt[idx_n];
`ifdef FLASH_LOOP_EN
               if (!sta)
                  state_d = IDLE;
`else
               cnt_d = cnt_q + FW'(1);
               if (cnt_q == CNT_LAST)
                  state_d = DONE;
`endif
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
      f0_d   = busy_d && (CW'(us_d) < CW'(width_d));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ps_q    <= '0;
         us_q    <= '0;
         idx_q   <= '0;
         width_q <= '0;
         f0      <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         ps_q    <= ps_d;
         us_q    <= us_d;
         idx_q   <= idx_d;
         width_q <= width_d;
         f0      <= f0_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

`ifndef FLASH_LOOP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_q[0] <= 10'd250;
         pat_q[1] <= 10'd150;
         pat_q[2] <= 10'd200;
         pat_q[3] <= 10'd180;
      end else if (wr_en) begin
         pat_q[wr_idx] <= wr_us;
      end
   end

endmodule
